// File: rtl/cla_pkg.sv
// Shared widths and state encoding for the cache-line to burst adaptor.
// ADAPTOR_LAST_BEAT_BYPASS_EN is consumed by cacheline_adaptor, not here.
package cla_pkg;

    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 2;
    localparam int OFFSET_W = 5;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } cla_state_t;

endpackage

// File: rtl/cla_beat_buffer.sv
// 256-bit line register with a full-line load, beat-indexed write and beat-indexed read.
// o_line_fwd shows the line with the current beat write already merged in.
module cla_beat_buffer
    import cla_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_beat_we,
    input  logic [CNT_W-1:0]  i_wr_idx,
    input  logic [BEAT_W-1:0] i_wr_beat,
    input  logic [CNT_W-1:0]  i_rd_idx,
    output logic [BEAT_W-1:0] o_rd_beat,
    output logic [LINE_W-1:0] o_line_fwd
);

    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] w_line_fwd;

    always_comb begin
        w_line_fwd = r_line;
        if (i_beat_we) begin
            w_line_fwd[32'(i_wr_idx)*BEAT_W +: BEAT_W] = i_wr_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else begin
            r_line <= w_line_fwd;
        end
    end

    assign o_rd_beat  = r_line[32'(i_rd_idx)*BEAT_W +: BEAT_W];
    assign o_line_fwd = w_line_fwd;

endmodule

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit line reads/writes into four 64-bit bursts to physical memory.
// Define ADAPTOR_LAST_BEAT_BYPASS_EN to respond in the cycle of the last beat, skipping DONE.
module cacheline_adaptor
    import cla_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [ADDR_W-1:0] line_address,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i
);

    cla_state_t        r_state;
    cla_state_t        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_rdata;
    logic [LINE_W-1:0] w_line_fwd;
    logic [BEAT_W-1:0] w_rd_beat;
    logic              w_busy;
    logic              w_last;
    logic              w_start_rd;
    logic              w_start_wr;

    assign w_busy     = (r_state == RD) || (r_state == WR);
    assign w_last     = w_busy && resp_i && (r_cnt == CNT_W'(BEATS - 1));
    assign w_start_rd = (r_state == IDLE) && line_read;
    assign w_start_wr = (r_state == IDLE) && !line_read && line_write;

    cla_beat_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start_wr),
        .i_line     (line_wdata),
        .i_beat_we  ((r_state == RD) && resp_i),
        .i_wr_idx   (r_cnt),
        .i_wr_beat  (burst_i),
        .i_rd_idx   (r_cnt),
        .o_rd_beat  (w_rd_beat),
        .o_line_fwd (w_line_fwd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (line_read) begin
                    w_next_state = RD;
                end else if (line_write) begin
                    w_next_state = WR;
                end
            end
            RD, WR: begin
                if (w_last) begin
`ifdef ADAPTOR_LAST_BEAT_BYPASS_EN
                    w_next_state = IDLE;
`else
                    w_next_state = DONE;
`endif
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The completed read line is captured on the last beat so it stays stable through later writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start_rd || w_start_wr) begin
                r_cnt  <= '0;
                r_addr <= line_address & LINE_MASK;
            end else if (w_busy && resp_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == RD) && w_last) begin
                r_rdata <= w_line_fwd;
            end
        end
    end

    always_comb begin
        line_rdata = r_rdata;
        line_resp  = 1'b0;
        read_o     = 1'b0;
        write_o    = 1'b0;
        address_o  = '0;
        burst_o    = '0;
        case (r_state)
            RD: begin
                read_o    = 1'b1;
                address_o = r_addr;
`ifdef ADAPTOR_LAST_BEAT_BYPASS_EN
                if (w_last) begin
                    line_resp  = 1'b1;
                    line_rdata = w_line_fwd;
                end
`endif
            end
            WR: begin
                write_o   = 1'b1;
                address_o = r_addr;
                burst_o   = w_rd_beat;
`ifdef ADAPTOR_LAST_BEAT_BYPASS_EN
                line_resp = w_last;
`endif
            end
            DONE:    line_resp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_cacheline_adaptor;

`ifdef ADAPTOR_LAST_BEAT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         read_o;
    logic         write_o;
    logic [31:0]  address_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .read_o       (read_o),
        .write_o      (write_o),
        .address_o    (address_o),
        .burst_o      (burst_o),
        .burst_i      (burst_i),
        .resp_i       (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Transaction-level model: op 0=none, 1=line read, 2=line write.
    int           m_op;
    int           m_beats;
    bit           m_respond;
    logic [31:0]  m_addr;
    logic [255:0] m_wline;
    logic [255:0] m_acc;
    logic [255:0] m_rline;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_op      <= 0;
            m_beats   <= 0;
            m_respond <= 1'b0;
            m_addr    <= '0;
            m_rline   <= '0;
        end else if (m_respond) begin
            m_respond <= 1'b0;
        end else if (m_op == 0) begin
            if (line_read) begin
                m_op    <= 1;
                m_addr  <= line_address & 32'hFFFF_FFE0;
                m_beats <= 0;
            end else if (line_write) begin
                m_op    <= 2;
                m_addr  <= line_address & 32'hFFFF_FFE0;
                m_wline <= line_wdata;
                m_beats <= 0;
            end
        end else if (resp_i) begin
            if (m_op == 1) m_acc[m_beats*64 +: 64] <= burst_i;
            if (m_beats == 3) begin
                if (m_op == 1) m_rline <= {burst_i, m_acc[191:0]};
                m_op      <= 0;
                m_beats   <= 0;
                m_respond <= !BYPASS;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    int           resp_cnt = 0;
    logic [255:0] resp_rdata = '0;
    bit           wr_seen = 1'b0;
    bit           e_final;
    logic [255:0] e_rdata;
    logic [63:0]  e_burst;

    always @(negedge clk) begin
        e_final = BYPASS && (m_op != 0) && resp_i && (m_beats == 3);
        e_rdata = (e_final && m_op == 1) ? {burst_i, m_acc[191:0]} : m_rline;
        e_burst = (m_op == 2 && m_beats < 4) ? m_wline[m_beats*64 +: 64] : 64'h0;
        chk("cyc_read_o",    read_o,    m_op == 1);
        chk("cyc_write_o",   write_o,   m_op == 2);
        chk("cyc_address_o", address_o, (m_op != 0) ? m_addr : 32'h0);
        chk("cyc_burst_o",   burst_o,   e_burst);
        chk("cyc_line_resp", line_resp, m_respond || e_final);
        chk("cyc_line_rdata", line_rdata, e_rdata);
        if (line_resp) begin
            resp_cnt++;
            resp_rdata = line_rdata;
        end
        if (write_o) wr_seen = 1'b1;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_beats(input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < 4; i++) begin
            resp_i  = 1'b1;
            burst_i = b[i];
            step();
        end
        resp_i  = 1'b0;
        burst_i = '0;
    endtask

    localparam logic [255:0] LINE1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE4 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                      64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    logic [63:0] wd [4];
    int base;

    initial begin
        wd[0] = 64'hD0D0_0000_0000_00D0;
        wd[1] = 64'hD1D1_0000_0000_00D1;
        wd[2] = 64'hD2D2_0000_0000_00D2;
        wd[3] = 64'hD3D3_0000_0000_00D3;
        rst = 1'b1; line_read = 1'b0; line_write = 1'b0;
        line_address = '0; line_wdata = '0; burst_i = '0; resp_i = 1'b0;
        step(2);
        rst = 1'b0;
        step();
        chk("reset_line_rdata", line_rdata, 256'h0);
        chk("reset_read_o", read_o, 1'b0);

        // resp_i in IDLE is ignored
        resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        step(2);
        resp_i = 1'b0; burst_i = '0;
        step();
        chk("idle_resp_ignored", resp_cnt, 0);

        // aligned line read, contiguous beats
        base = resp_cnt;
        line_address = 32'h0000_1234; line_read = 1'b1;
        step();
        line_read = 1'b0; line_address = '0;
        chk("t1_address_o", address_o, 32'h0000_1220);
        read_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        step(2);
        chk("t1_resp_count", resp_cnt, base + 1);
        chk("t1_rdata_at_resp", resp_rdata, LINE1);
        chk("t1_rdata_hold", line_rdata, LINE1);

        // line write with two idle cycles before each beat
        base = resp_cnt;
        line_address = 32'h8000_0040; line_wdata = {wd[3], wd[2], wd[1], wd[0]}; line_write = 1'b1;
        step();
        line_write = 1'b0; line_wdata = '0;
        chk("t2_address_o", address_o, 32'h8000_0040);
        for (int i = 0; i < 4; i++) begin
            step(2);
            chk("t2_burst_gap", burst_o, wd[i]);
            resp_i = 1'b1;
            chk("t2_burst_beat", burst_o, wd[i]);
            step();
            resp_i = 1'b0;
        end
        step(2);
        chk("t2_resp_count", resp_cnt, base + 1);
        chk("t2_rdata_untouched", line_rdata, LINE1);

        // both requests together: read wins
        base = resp_cnt;
        wr_seen = 1'b0;
        line_address = 32'h0000_2000; line_read = 1'b1; line_write = 1'b1; line_wdata = {4{64'hFFFF}};
        step();
        line_read = 1'b0; line_write = 1'b0;
        chk("t3_read_o", read_o, 1'b1);
        chk("t3_write_o", write_o, 1'b0);
        read_beats(64'h5, 64'h6, 64'h7, 64'h8);
        step(2);
        chk("t3_no_write", wr_seen, 1'b0);
        chk("t3_resp_count", resp_cnt, base + 1);
        chk("t3_rdata", line_rdata, {64'h8, 64'h7, 64'h6, 64'h5});

        // reset mid-burst after three beats
        base = resp_cnt;
        line_address = 32'h0000_3000; line_read = 1'b1;
        step();
        line_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1; burst_i = 64'hBAD0 + 64'(i);
            step();
        end
        resp_i = 1'b0; burst_i = '0;
        rst = 1'b1;
        #1;
        chk("t4_rst_read_o", read_o, 1'b0);
        chk("t4_rst_address_o", address_o, 32'h0);
        chk("t4_rst_line_rdata", line_rdata, 256'h0);
        step();
        rst = 1'b0;
        resp_i = 1'b1; burst_i = 64'hBAD3;
        step();
        resp_i = 1'b0; burst_i = '0;
        step(3);
        chk("t4_no_resp", resp_cnt, base);
        line_address = 32'h0000_4010; line_read = 1'b1;
        step();
        line_read = 1'b0;
        read_beats(64'hA0A0_0000_0000_0000, 64'hA1A1_0000_0000_0001,
                   64'hA2A2_0000_0000_0002, 64'hA3A3_0000_0000_0003);
        step(2);
        chk("t4_resp_count", resp_cnt, base + 1);
        chk("t4_rdata", resp_rdata, LINE4);

        // address changes during a read do not leak to address_o
        base = resp_cnt;
        line_address = 32'h0000_5008; line_read = 1'b1;
        step();
        line_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            line_address = 32'h1357_9BDF ^ (32'h1111_1111 * 32'(i));
            resp_i = 1'b0;
            step();
            chk("t5_address_hold", address_o, 32'h0000_5000);
            resp_i = 1'b1; burst_i = 64'hC0 + 64'(i);
            step();
        end
        resp_i = 1'b0; burst_i = '0;
        step(2);
        chk("t5_resp_count", resp_cnt, base + 1);
        chk("t5_rdata", line_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});

        step(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
